// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl
//   Instruction-fetch controller for a 1K-word instruction memory with a
//   combinational read port. It owns the fetch PC and drives the memory word
//   address. Each returned word is pushed with its PC into a small FIFO. The
//   FIFO head is handed to decode over a valid/ready handshake.
//   A redirect flushes the FIFO and reloads the PC. A redirect to a
//   misaligned target latches a sticky fault instead. The fault clears only
//   on reset. Halt stops fetching, but the FIFO keeps draining.
//
// Ports
//   clk             in   1   rising-edge clock
//   reset           in   1   synchronous, active-high
//   im_addr         out  10  instruction memory word address (fetch_pc[11:2])
//   im_data         in   32  instruction word read combinationally at im_addr
//   redirect_valid  in   1   one-cycle redirect request
//   redirect_pc     in   32  redirect target
//   halt            in   1   level: suspend fetching
//   out_valid       out  1   FIFO head valid
//   out_ready       in   1   decode accepts the head this cycle
//   out_instr       out  32  head instruction
//   out_pc          out  32  head PC
//   fault           out  1   sticky misaligned-redirect flag
module im_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  // Last head seen. It keeps out_* stable while the FIFO is empty.
  logic [31:0] last_instr_reg, last_pc_reg;

  logic        fifo_empty, fifo_full;
  logic        push, pop, flush;
  logic [31:0] head_instr, head_pc;

  assign im_addr    = fetch_pc_reg[11:2];
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign head_instr = instr_mem[rd_ptr_reg[AW-1:0]];
  assign head_pc    = pc_mem[rd_ptr_reg[AW-1:0]];

  assign out_valid  = !fifo_empty && (state_reg != S_FAULT);
  assign out_instr  = fifo_empty ? last_instr_reg : head_instr;
  assign out_pc     = fifo_empty ? last_pc_reg    : head_pc;
  assign fault      = (state_reg == S_FAULT);

  // Next-state, PC and FIFO control.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    push          = 1'b0;
    flush         = 1'b0;
    pop           = out_valid && out_ready;

    if (redirect_valid && (state_reg != S_FAULT)) begin
      // A redirect discards everything in flight, including a pop offered this cycle.
      flush = 1'b1;
      pop   = 1'b0;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc_next = redirect_pc;
        state_next    = halt ? S_HOLD : S_RUN;
      end else begin
        state_next = S_FAULT;
      end
    end else begin
      case (state_reg)
        S_RUN: begin
          if (halt) begin
            state_next = S_HOLD;
          end else if (!fifo_full) begin
            // Full blocks the push even if a pop frees a slot this cycle.
            push          = 1'b1;
            fetch_pc_next = fetch_pc_reg + 32'd4;
          end
        end
        S_HOLD: begin
          if (!halt) begin
            state_next = S_RUN;
          end
        end
        S_FAULT: begin
          flush = 1'b1;
          pop   = 1'b0;
        end
        default: begin
          state_next = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_RUN;
      fetch_pc_reg   <= PC_RESET;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      last_instr_reg <= '0;
      last_pc_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (!fifo_empty) begin
        last_instr_reg <= head_instr;
        last_pc_reg    <= head_pc;
      end
    end
  end

  // FIFO storage needs no reset. The pointers alone decide which slots hold valid data.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem[wr_ptr_reg[AW-1:0]] <= im_data;
      pc_mem[wr_ptr_reg[AW-1:0]]    <= fetch_pc_reg;
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
module tb_im_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [9:0]  im_addr;
  logic [31:0] im_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  logic [31:0] im_mem [1024];

  int errors = 0;
  int checks = 0;

  im_fetch_ctrl #(.PC_RESET(32'h0000_3000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  // Instruction memory: the word at index i is 0xA000_0000 + i.
  assign im_data = im_mem[im_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check handshake, head PC/instruction and memory address in one go.
  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [9:0] addr);
    logic [31:0] exp_instr;
    exp_instr = 32'hA000_0000 | {22'd0, pc[11:2]};
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".pc"}, out_pc, pc);
    if (v) chk({tag, ".instr"}, out_instr, exp_instr);
    chk({tag, ".addr"}, {22'd0, im_addr}, {22'd0, addr});
    $display("step %s: valid=%0d pc=%h instr=%h addr=%h fault=%0d",
             tag, out_valid, out_pc, out_instr, im_addr, fault);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) im_mem[i] = 32'hA000_0000 + i;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    out_ready      = 1'b1;

    // Reset state.
    cyc();
    cyc();
    expect_out("reset", 1'b0, 32'h0, 10'h000);
    chk("reset.instr", out_instr, 32'h0);
    chk("reset.fault", {31'd0, fault}, 32'd0);
    reset = 1'b0;

    // 1: streaming with decode always ready.
    cyc(); expect_out("t1.0", 1'b1, 32'h3000, 10'h001);
    cyc(); expect_out("t1.1", 1'b1, 32'h3004, 10'h002);
    cyc(); expect_out("t1.2", 1'b1, 32'h3008, 10'h003);

    // 2: back-pressure fills the FIFO and freezes the PC.
    out_ready = 1'b0;
    cyc(); expect_out("t2.fill", 1'b1, 32'h3008, 10'h004);
    cyc(); expect_out("t2.full0", 1'b1, 32'h3008, 10'h004);
    cyc(); expect_out("t2.full1", 1'b1, 32'h3008, 10'h004);
    cyc(); expect_out("t2.full2", 1'b1, 32'h3008, 10'h004);
    out_ready = 1'b1;
    cyc(); expect_out("t2.rel0", 1'b1, 32'h300C, 10'h004);
    cyc(); expect_out("t2.rel1", 1'b1, 32'h3010, 10'h005);
    out_ready = 1'b0;
    cyc(); expect_out("t2.refill", 1'b1, 32'h3010, 10'h006);

    // 3: aligned redirect while full.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3040;
    cyc(); expect_out("t3.flush", 1'b0, 32'h3010, 10'h010);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    cyc(); expect_out("t3.new0", 1'b1, 32'h3040, 10'h011);
    cyc(); expect_out("t3.new1", 1'b1, 32'h3044, 10'h012);

    // 4: halt drains the FIFO. Fetch then resumes at the frozen PC.
    halt = 1'b1;
    cyc(); expect_out("t4.h0", 1'b0, 32'h3044, 10'h012);
    cyc(); expect_out("t4.h1", 1'b0, 32'h3044, 10'h012);
    cyc(); expect_out("t4.h2", 1'b0, 32'h3044, 10'h012);
    halt = 1'b0;
    cyc(); expect_out("t4.res0", 1'b0, 32'h3044, 10'h012);
    cyc(); expect_out("t4.res1", 1'b1, 32'h3048, 10'h013);
    cyc(); expect_out("t4.res2", 1'b1, 32'h304C, 10'h014);

    // 5: misaligned redirect faults. Later redirects are ignored until reset.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3042;
    cyc(); expect_out("t5.f0", 1'b0, 32'h304C, 10'h014);
    chk("t5.fault0", {31'd0, fault}, 32'd1);
    redirect_valid = 1'b0;
    cyc(); expect_out("t5.f1", 1'b0, 32'h304C, 10'h014);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3100;
    cyc(); expect_out("t5.f2", 1'b0, 32'h304C, 10'h014);
    chk("t5.fault2", {31'd0, fault}, 32'd1);
    redirect_valid = 1'b0;
    reset = 1'b1;
    cyc(); expect_out("t5.rst", 1'b0, 32'h0, 10'h000);
    chk("t5.fault_clr", {31'd0, fault}, 32'd0);
    reset = 1'b0;
    cyc(); expect_out("t5.r0", 1'b1, 32'h3000, 10'h001);
    cyc(); expect_out("t5.r1", 1'b1, 32'h3004, 10'h002);

    // 6: reset beats a simultaneous redirect. Then check address and PC wrap.
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3040;
    cyc(); expect_out("t6.rst", 1'b0, 32'h0, 10'h000);
    reset       = 1'b0;
    redirect_pc = 32'h0000_3FFC;
    cyc(); expect_out("t6.rd", 1'b0, 32'h0, 10'h3FF);
    redirect_valid = 1'b0;
    cyc(); expect_out("t6.w0", 1'b1, 32'h3FFC, 10'h000);
    cyc(); expect_out("t6.w1", 1'b1, 32'h4000, 10'h001);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc(); expect_out("t6.top", 1'b0, 32'h4000, 10'h3FF);
    redirect_valid = 1'b0;
    cyc(); expect_out("t6.p0", 1'b1, 32'hFFFF_FFFC, 10'h000);
    cyc(); expect_out("t6.p1", 1'b1, 32'h0000_0000, 10'h001);
    chk("t6.fault", {31'd0, fault}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
